// File: rtl/vx_issue_scoreboard.sv
// Issue-stage scoreboard: per-warp register reservation bits with a registered lookahead hazard flag.
// Define SCOREBOARD_PERF_EN to build the hazard-stall cycle counter on perf_stalls.
module vx_issue_scoreboard #(
    parameter  int unsigned NUM_WARPS = 4,
    parameter  int unsigned NUM_REGS  = 64,
    localparam int unsigned NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int unsigned NR_BITS   = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ibuf_valid,
    output logic               ibuf_ready,
    input  logic [NW_BITS-1:0] ibuf_wid,
    input  logic               ibuf_wb,
    input  logic [NR_BITS-1:0] ibuf_rd,
    input  logic [NR_BITS-1:0] ibuf_rs1,
    input  logic [NR_BITS-1:0] ibuf_rs2,
    input  logic [NR_BITS-1:0] ibuf_rs3,
    input  logic [NW_BITS-1:0] ibuf_wid_n,
    input  logic [NR_BITS-1:0] ibuf_rd_n,
    input  logic [NR_BITS-1:0] ibuf_rs1_n,
    input  logic [NR_BITS-1:0] ibuf_rs2_n,
    input  logic [NR_BITS-1:0] ibuf_rs3_n,
    output logic               issue_valid,
    input  logic               issue_ready,
    input  logic               wb_valid,
    input  logic [NW_BITS-1:0] wb_wid,
    input  logic [NR_BITS-1:0] wb_rd,
    input  logic               wb_eop,
    output logic [31:0]        perf_stalls
);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse_q, inuse_d;
    logic stall_q, stall_d;
    logic issue_fire;
    logic unused_head_srcs;

    assign issue_valid = ibuf_valid && !stall_q;
    assign ibuf_ready  = issue_ready && !stall_q;
    assign issue_fire  = ibuf_valid && ibuf_ready;

    // The head's sources were already checked one cycle earlier through the lookahead ports.
    assign unused_head_srcs = ^{ibuf_rs1, ibuf_rs2, ibuf_rs3};

    // Reservation update (set beats clear) and hazard lookup for next cycle's head.
    always_comb begin
        inuse_d = inuse_q;
        if (wb_valid && wb_eop) begin
            inuse_d[wb_wid][wb_rd] = 1'b0;
        end
        if (issue_fire && ibuf_wb && (ibuf_rd != NR_BITS'(0))) begin
            inuse_d[ibuf_wid][ibuf_rd] = 1'b1;
        end
        stall_d = inuse_d[ibuf_wid_n][ibuf_rd_n]
                | inuse_d[ibuf_wid_n][ibuf_rs1_n]
                | inuse_d[ibuf_wid_n][ibuf_rs2_n]
                | inuse_d[ibuf_wid_n][ibuf_rs3_n];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inuse_q <= '0;
            stall_q <= 1'b0;
        end else begin
            inuse_q <= inuse_d;
            stall_q <= stall_d;
        end
    end

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Counts cycles where a valid head is held back by a hazard; wraps naturally.
    always_comb begin
        perf_d = perf_q;
        if (ibuf_valid && stall_q) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stalls = perf_q;
`else
    assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// Scoreboard bench for vx_issue_scoreboard: directed hazard scenarios followed by a random
// instruction stream, checked against a reservation-set reference model.
module tb_vx_issue_scoreboard;

    localparam int unsigned NUM_WARPS = 4;
    localparam int unsigned NUM_REGS  = 64;
    localparam int unsigned NW        = 2;
    localparam int unsigned NR        = 6;

    typedef struct {
        bit          rst_n, v, wb, irdy, wbv, wbe;
        bit [NW-1:0] wid, wid_n, wbw;
        bit [NR-1:0] rd, rs1, rs2, rs3, rd_n, rs1_n, rs2_n, rs3_n, wbr;
    } stim_t;

    typedef struct {
        bit [NW-1:0] wid;
        bit          wb;
        bit [NR-1:0] rd, rs1, rs2, rs3;
    } instr_t;

    typedef struct {
        bit        iv;
        bit        ir;
        bit [31:0] perf;
    } exp_t;

    logic          clk, reset;
    logic          ibuf_valid, ibuf_ready, ibuf_wb;
    logic [NW-1:0] ibuf_wid, ibuf_wid_n, wb_wid;
    logic [NR-1:0] ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
    logic [NR-1:0] ibuf_rd_n, ibuf_rs1_n, ibuf_rs2_n, ibuf_rs3_n, wb_rd;
    logic          issue_valid, issue_ready, wb_valid, wb_eop;
    logic [31:0]   perf_stalls;

    vx_issue_scoreboard #(.NUM_WARPS(NUM_WARPS), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .reset(reset),
        .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready),
        .ibuf_wid(ibuf_wid), .ibuf_wb(ibuf_wb),
        .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3),
        .ibuf_wid_n(ibuf_wid_n), .ibuf_rd_n(ibuf_rd_n),
        .ibuf_rs1_n(ibuf_rs1_n), .ibuf_rs2_n(ibuf_rs2_n), .ibuf_rs3_n(ibuf_rs3_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .perf_stalls(perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];

    // Reference model: set of reserved (warp, reg) pairs plus the predicted hazard flag.
    bit        pend[int];
    bit        stall_exp = 1'b0;
    bit [31:0] perf_exp  = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int key(bit [NW-1:0] w, bit [NR-1:0] r);
        return int'(w) * int'(NUM_REGS) + int'(r);
    endfunction

    function automatic bit busy(bit [NW-1:0] w, bit [NR-1:0] r);
        return pend.exists(key(w, r)) != 0;
    endfunction

    function automatic instr_t mk(int w, bit wb, int rd, int a, int b, int c);
        instr_t i;
        i.wid = NW'(w); i.wb = wb; i.rd = NR'(rd);
        i.rs1 = NR'(a); i.rs2 = NR'(b); i.rs3 = NR'(c);
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        return mk(int'($urandom_range(0, NUM_WARPS - 1)), ($urandom % 4) != 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst_n = 1'b1;
        s.irdy  = 1'b1;
        return s;
    endfunction

    function automatic stim_t put(stim_t s, instr_t h, instr_t n);
        s.wid = h.wid; s.wb = h.wb; s.rd = h.rd;
        s.rs1 = h.rs1; s.rs2 = h.rs2; s.rs3 = h.rs3;
        s.wid_n = n.wid; s.rd_n = n.rd;
        s.rs1_n = n.rs1; s.rs2_n = n.rs2; s.rs3_n = n.rs3;
        return s;
    endfunction

    // Drive one cycle, queue the expected response, then advance the model past the next edge.
    task automatic step(input stim_t s, output bit fired);
        exp_t e;
        @(posedge clk);
        #1;
        reset = s.rst_n; ibuf_valid = s.v; issue_ready = s.irdy;
        ibuf_wid = s.wid; ibuf_wb = s.wb; ibuf_rd = s.rd;
        ibuf_rs1 = s.rs1; ibuf_rs2 = s.rs2; ibuf_rs3 = s.rs3;
        ibuf_wid_n = s.wid_n; ibuf_rd_n = s.rd_n;
        ibuf_rs1_n = s.rs1_n; ibuf_rs2_n = s.rs2_n; ibuf_rs3_n = s.rs3_n;
        wb_valid = s.wbv; wb_wid = s.wbw; wb_rd = s.wbr; wb_eop = s.wbe;
        if (!s.rst_n) begin
            pend.delete();
            stall_exp = 1'b0;
            perf_exp  = 32'd0;
        end
        e.iv = s.v && !stall_exp;
        e.ir = s.irdy && !stall_exp;
        e.perf = perf_exp;
        exp_q.push_back(e);
        fired = s.rst_n && s.v && s.irdy && !stall_exp;
        if (s.rst_n) begin
            if (s.wbv && s.wbe && busy(s.wbw, s.wbr)) pend.delete(key(s.wbw, s.wbr));
            if (fired && s.wb && s.rd != NR'(0)) pend[key(s.wid, s.rd)] = 1'b1;
`ifdef SCOREBOARD_PERF_EN
            if (s.v && stall_exp) perf_exp = perf_exp + 32'd1;
`endif
            stall_exp = busy(s.wid_n, s.rd_n) || busy(s.wid_n, s.rs1_n)
                     || busy(s.wid_n, s.rs2_n) || busy(s.wid_n, s.rs3_n);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("issue_valid", 32'(issue_valid), 32'(e.iv));
            chk("ibuf_ready", 32'(ibuf_ready), 32'(e.ir));
            chk("perf_stalls", perf_stalls, e.perf);
        end
    end

    initial begin
        stim_t  s;
        bit     f;
        bit     pred;
        int     idx;
        instr_t nop;
        instr_t iq[$];
        instr_t outq[$];

        reset = 1'b0; ibuf_valid = 1'b0; issue_ready = 1'b0; ibuf_wid = '0; ibuf_wb = 1'b0;
        ibuf_rd = '0; ibuf_rs1 = '0; ibuf_rs2 = '0; ibuf_rs3 = '0;
        ibuf_wid_n = '0; ibuf_rd_n = '0; ibuf_rs1_n = '0; ibuf_rs2_n = '0; ibuf_rs3_n = '0;
        wb_valid = 1'b0; wb_wid = '0; wb_rd = '0; wb_eop = 1'b0;
        nop = mk(0, 1'b0, 0, 0, 0, 0);

        // Reset with a valid head: outputs follow inputs.
        s = idle(); s.rst_n = 1'b0; s.v = 1'b1;
        repeat (2) step(s, f);

        // w0 rd=5 issues at once; dependent w0 rs1=5 waits for the eop writeback.
        s = put(idle(), mk(0, 1'b1, 5, 1, 2, 3), mk(0, 1'b0, 0, 5, 0, 0)); s.v = 1'b1;
        step(s, f);
        s = put(idle(), mk(0, 1'b0, 0, 5, 0, 0), mk(0, 1'b0, 0, 5, 0, 0)); s.v = 1'b1;
        repeat (3) step(s, f);
        s.wbv = 1'b1; s.wbw = NW'(0); s.wbr = NR'(5); s.wbe = 1'b0;
        step(s, f);
        s.wbe = 1'b1;
        step(s, f);
        s = put(idle(), mk(0, 1'b0, 0, 5, 0, 0), nop); s.v = 1'b1;
        step(s, f);

        // Same-cycle set and clear of w1 r7: the reservation survives.
        s = put(idle(), mk(1, 1'b1, 7, 0, 0, 0), mk(1, 1'b0, 0, 0, 7, 0)); s.v = 1'b1;
        s.wbv = 1'b1; s.wbw = NW'(1); s.wbr = NR'(7); s.wbe = 1'b1;
        step(s, f);
        s = put(idle(), mk(1, 1'b0, 0, 0, 7, 0), mk(1, 1'b0, 0, 0, 7, 0)); s.v = 1'b1;
        repeat (2) step(s, f);
        s.wbv = 1'b1; s.wbw = NW'(1); s.wbr = NR'(7); s.wbe = 1'b1;
        step(s, f);
        s = put(idle(), mk(1, 1'b0, 0, 0, 7, 0), nop); s.v = 1'b1;
        step(s, f);

        // x0 is never reserved; other warps never hazard.
        s = put(idle(), mk(2, 1'b1, 0, 0, 0, 0), mk(2, 1'b0, 0, 0, 0, 0)); s.v = 1'b1;
        step(s, f);
        s = put(idle(), mk(2, 1'b0, 0, 0, 0, 0), mk(0, 1'b1, 5, 0, 0, 0)); s.v = 1'b1;
        step(s, f);
        s = put(idle(), mk(0, 1'b1, 5, 0, 0, 0), mk(3, 1'b0, 0, 5, 0, 0)); s.v = 1'b1;
        step(s, f);
        s = put(idle(), mk(3, 1'b0, 0, 5, 0, 0), mk(0, 1'b0, 0, 5, 0, 0)); s.v = 1'b1;
        step(s, f);

        // Ten stalled valid cycles on w0 r5.
        s = put(idle(), mk(0, 1'b0, 0, 5, 0, 0), mk(0, 1'b0, 0, 5, 0, 0)); s.v = 1'b1;
        repeat (9) step(s, f);
        s = put(s, mk(0, 1'b0, 0, 5, 0, 0), mk(1, 1'b1, 3, 0, 0, 0));
        step(s, f);

        // Three pending reservations, a blocked head, then reset releases it.
        s = put(idle(), mk(1, 1'b1, 3, 0, 0, 0), mk(2, 1'b1, 4, 0, 0, 0)); s.v = 1'b1;
        step(s, f);
        s = put(idle(), mk(2, 1'b1, 4, 0, 0, 0), mk(1, 1'b0, 0, 3, 0, 0)); s.v = 1'b1;
        step(s, f);
        s = put(idle(), mk(1, 1'b0, 0, 3, 0, 0), mk(1, 1'b0, 0, 3, 0, 0)); s.v = 1'b1;
        repeat (2) step(s, f);
        s.rst_n = 1'b0;
        repeat (2) step(s, f);
        s = put(idle(), mk(1, 1'b0, 0, 3, 0, 0), mk(0, 1'b0, 0, 5, 0, 0)); s.v = 1'b1;
        s.wbv = 1'b1; s.wbw = NW'(0); s.wbr = NR'(5); s.wbe = 1'b1;
        step(s, f);
        s = put(idle(), mk(0, 1'b0, 0, 5, 0, 0), nop); s.v = 1'b1;
        step(s, f);

        // Random instruction stream with a consistent lookahead and random writebacks.
        for (int c = 0; c < 3000; c++) begin
            while (iq.size() < 2) iq.push_back(rnd_instr());
            s = idle();
            s.v = ($urandom % 8) != 0;
            s.irdy = ($urandom % 6) != 0;
            pred = s.v && s.irdy && !stall_exp;
            s = put(s, iq[0], pred ? iq[1] : iq[0]);
            if (outq.size() != 0 && ($urandom % 3) == 0) begin
                idx = int'($urandom_range(0, outq.size() - 1));
                s.wbv = 1'b1; s.wbw = outq[idx].wid; s.wbr = outq[idx].rd;
                s.wbe = ($urandom % 4) != 0;
                if (s.wbe) outq.delete(idx);
            end else if (($urandom % 10) == 0) begin
                s.wbv = 1'b1; s.wbw = NW'($urandom_range(0, NUM_WARPS - 1));
                s.wbr = NR'($urandom_range(0, 7)); s.wbe = ($urandom % 2) != 0;
            end
            if (c == 1500) s.rst_n = 1'b0;
            step(s, f);
            if (f) begin
                if (iq[0].wb && iq[0].rd != NR'(0)) outq.push_back(iq[0]);
                void'(iq.pop_front());
            end
            if (!s.rst_n) outq.delete();
        end

        s = idle();
        repeat (3) step(s, f);
        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vx_issue_scoreboard.md
VX_ISSUE_SCOREBOARD -- requirements
Module: VX_issue_scoreboard

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of hardware warps.
REQ-002 SHALL have parameter NUM_REGS, default 64, architectural registers per warp (int+fp); register 0 is x0.
REQ-003 SHALL derive NW_BITS = max(1, clog2(NUM_WARPS)) and NR_BITS = clog2(NUM_REGS).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 ibuf_valid  input  1  instruction-buffer head valid.
REQ-007 ibuf_ready  output  1  head accepted this cycle.
REQ-008 ibuf_wid  input  NW_BITS  head warp id.
REQ-009 ibuf_wb  input  1  head writes rd.
REQ-010 ibuf_rd / ibuf_rs1 / ibuf_rs2 / ibuf_rs3  input  NR_BITS each  head register indices.
REQ-011 ibuf_wid_n / ibuf_rd_n / ibuf_rs1_n / ibuf_rs2_n / ibuf_rs3_n  input  NW_BITS / NR_BITS  next-cycle head lookahead from the buffer.
REQ-012 issue_valid  output  1  hazard-free instruction offered downstream.
REQ-013 issue_ready  input  1  downstream accepts.
REQ-014 wb_valid  input  1  writeback beat.
REQ-015 wb_wid / wb_rd  input  NW_BITS / NR_BITS  writeback target.
REQ-016 wb_eop  input  1  last beat of the writeback.
REQ-017 perf_stalls  output  32  hazard stall cycle count.

Function
REQ-018 SHALL hold an inuse bit per (warp, register), NUM_WARPS x NUM_REGS.
REQ-019 Issue fire = ibuf_valid && ibuf_ready; on fire with ibuf_wb=1 and ibuf_rd!=0, SHALL set inuse[ibuf_wid][ibuf_rd] at the next edge.
REQ-020 On wb_valid && wb_eop, SHALL clear inuse[wb_wid][wb_rd] at the next edge; wb_valid without wb_eop SHALL leave state unchanged.
REQ-021 Set and clear of the same entry in one cycle: set wins (entry stays 1).
REQ-022 Entry for register 0 SHALL never be set.
REQ-023 SHALL register hazard flag stall_r = OR of inuse_next[ibuf_wid_n] at rd_n, rs1_n, rs2_n, rs3_n, where inuse_next includes this cycle's set/clear (REQ-019..021).
REQ-024 issue_valid = ibuf_valid && !stall_r; ibuf_ready = issue_ready && !stall_r; purely combinational from stall_r, no extra latency.
REQ-025 Zero-cycle pass-through: hazard-free head with issue_ready=1 issues the cycle it appears.
REQ-026 Writeback clearing a hazard SHALL release the stalled head the cycle after the wb edge (1-cycle wakeup).
REQ-027 Back-to-back dependent instructions of the same warp: second SHALL stall (stall_r=1) the cycle after the first issues.
REQ-028 Different warps SHALL never hazard each other.
REQ-029 stall_r SHALL be 0 whenever no entry in the lookahead warp is set.

Reset
REQ-030 While reset=0, all inuse bits = 0, stall_r = 0, perf_stalls = 0; hence issue_valid = ibuf_valid, ibuf_ready = issue_ready.
REQ-031 Reset mid-operation SHALL discard all pending reservations immediately (asynchronous); later writebacks to those entries are harmless clears.

Configuration
REQ-032 Macro SCOREBOARD_PERF_EN: when defined, perf_stalls SHALL increment (wrap at 2^32) every cycle with ibuf_valid && stall_r.
REQ-033 Without SCOREBOARD_PERF_EN, perf_stalls SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-034 Reset, then head w0 rd=5 wb=1, issue_ready=1 -> issue_valid=1 same cycle, inuse[0][5]=1 next cycle.
REQ-035 w0 issues rd=5, next head w0 rs1=5 -> issue_valid=0 until wb_valid/eop w0 rd=5, then issue_valid=1 one cycle later.
REQ-036 Same cycle: issue w1 rd=7 and wb w1 rd=7 eop=1 -> inuse[1][7]=1 afterward; dependent w1 rs2=7 stalls.
REQ-037 w2 rd=0 wb=1 issued, then w2 rs1=0 -> no stall; w3 rs1=5 while w0 rd=5 pending -> no stall.
REQ-038 With SCOREBOARD_PERF_EN, 10 stalled valid cycles -> perf_stalls=10; without macro -> 0.
REQ-039 Assert reset=0 with 3 reservations pending -> stall_r=0, perf_stalls=0 during reset; after release, previously blocked head issues at once.
